// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
// Module      : seq_div
// Description : Sequential unsigned restoring divider. One quotient bit is
//               produced per clock, MSB first, so a division with a nonzero
//               divisor takes WIDTH cycles from the accepting edge to the
//               result edge. A zero divisor is detected on the first step
//               and completes after a single cycle with the dz flag set.
//               Handshake: start is accepted in IDLE or DONE (back-to-back
//               allowed) and ignored while a division runs; done pulses for
//               one cycle when quotient/remainder/dz become valid, and those
//               outputs hold until the next result or a reset.
// Config      : `define SEQ_DIV_REMAINDER_EN to build the remainder output
//               port and its result register. Without it the port and
//               register are absent; quotient, dz and timing are identical.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef SEQ_DIV_REMAINDER_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic             dz
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Step counter only needs to count 0..WIDTH-1.
    localparam int               CNT_W     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;       // index of the step about to execute
    logic [WIDTH-1:0] rem_q;       // partial remainder (always < divisor)
    logic [WIDTH-1:0] dvd_q;       // dividend bits shift out the top,
                                   // quotient bits shift in at the bottom
    logic [WIDTH-1:0] dvs_q;       // divisor latched at the accepting edge

    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] quotient_q;
`ifdef SEQ_DIV_REMAINDER_EN
    logic [WIDTH-1:0] remainder_q;
`endif

    // ------------------------------------------------------------------------
    // Next-step datapath
    // ------------------------------------------------------------------------
    // shift_d is the WIDTH+1 bit shifted partial remainder: the old remainder
    // can be as large as divisor-1, so after the shift it may need one extra
    // bit. The difference always fits in WIDTH bits because it is only kept
    // when it is smaller than the divisor.
    logic [WIDTH:0]   shift_d;
    logic [WIDTH-1:0] trial_d;
    logic             qbit_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // One restoring-division step: shift, trial subtract, keep or restore.
    always_comb begin
        shift_d = {rem_q, dvd_q[WIDTH-1]};
        trial_d = shift_d[WIDTH-1:0] - dvs_q;
        qbit_d  = (shift_d >= {1'b0, dvs_q});
        rem_d   = qbit_d ? trial_d : shift_d[WIDTH-1:0];
        quo_d   = {dvd_q[WIDTH-2:0], qbit_d};
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    // Sequences accept -> WIDTH steps -> result, and owns every output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
`ifdef SEQ_DIV_REMAINDER_EN
            remainder_q <= '0;
`endif
        end else begin
            // done is a single-cycle strobe; only the result edge raises it.
            done_q <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Accept: latch operands and clear the partial
                        // remainder. Result outputs keep their old values
                        // until the new result is registered.
                        dvd_q   <= dividend;
                        dvs_q   <= divisor;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_CALC: begin
                    if (dvs_q == '0) begin
                        // Divide-by-zero short cut on the first step: the
                        // dividend is still untouched in dvd_q.
                        quotient_q  <= '1;
`ifdef SEQ_DIV_REMAINDER_EN
                        remainder_q <= dvd_q;
`endif
                        dz_q        <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_STEP) begin
                            // Final step: publish the result straight from
                            // the step logic so it lands on edge E(WIDTH).
                            quotient_q  <= quo_d;
`ifdef SEQ_DIV_REMAINDER_EN
                            remainder_q <= rem_d;
`endif
                            dz_q        <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_DONE;
                        end
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign busy      = busy_q;
    assign done      = done_q;
    assign dz        = dz_q;
    assign quotient  = quotient_q;
`ifdef SEQ_DIV_REMAINDER_EN
    assign remainder = remainder_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_div
// Description : Scoreboard bench for seq_div. Stimulus pushes the expected
//               result (computed with plain / and %) and its expected done
//               cycle; a negedge monitor pops and compares whenever done is
//               seen, and also checks busy and result holding every cycle.
//               Build with and without SEQ_DIV_REMAINDER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div;

    localparam int W    = 8;
    localparam int MAXC = 16384;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    wire          busy;
    wire          done;
    wire          dz;
    wire  [W-1:0] quotient;
`ifdef SEQ_DIV_REMAINDER_EN
    wire  [W-1:0] remainder;
`endif

    seq_div #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
`ifdef SEQ_DIV_REMAINDER_EN
        .remainder(remainder),
`endif
        .dz       (dz)
    );

    always #5 clk = ~clk;

    // cyc == k at the negedge following rising edge k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int q;
        int r;
        int z;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   exp_busy [MAXC];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    int   last_q = 0;
    int   last_r = 0;
    int   last_z = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: busy every cycle, results when done, holding otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", {31'd0, busy}, {31'd0, exp_busy[cyc]});
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_cycle", cyc, mon_e.at);
                    chk("quotient", {24'd0, quotient}, mon_e.q);
`ifdef SEQ_DIV_REMAINDER_EN
                    chk("remainder", {24'd0, remainder}, mon_e.r);
`endif
                    chk("dz", {31'd0, dz}, mon_e.z);
                    last_q = mon_e.q;
                    last_r = mon_e.r;
                    last_z = mon_e.z;
                end
            end else begin
                if (sb.size() > 0 && sb[0].at <= cyc) begin
                    chk("done_missing", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
                if (!exp_busy[cyc]) begin
                    chk("hold_quotient", {24'd0, quotient}, last_q);
`ifdef SEQ_DIV_REMAINDER_EN
                    chk("hold_remainder", {24'd0, remainder}, last_r);
`endif
                    chk("hold_dz", {31'd0, dz}, last_z);
                end
            end
        end
    end

    // One division issued at the current negedge (accepted at the next edge).
    // hold  : keep start high throughout (junk operands during the run)
    // inj   : loop step at which a stray start with other operands is pulsed
    // rst_at: loop step at which rst is raised to abort (0 = none)
    // Returns at the negedge where done is expected (or just after reset).
    task automatic div(input int a, input int b, input bit hold,
                       input int inj, input int rst_at);
        int   lat;
        int   e0;
        int   nb;
        exp_t e;
        lat      = (b == 0) ? 1 : W;
        e0       = cyc + 1;
        start    = 1'b1;
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        nb       = (rst_at != 0) ? rst_at : lat;
        for (int k = 0; k < nb; k++) exp_busy[e0 + k] = 1'b1;
        if (rst_at == 0) begin
            e.q  = (b == 0) ? ((1 << W) - 1) : (a / b);
            e.r  = (b == 0) ? a : (a % b);
            e.z  = (b == 0) ? 1 : 0;
            e.at = e0 + lat;
            sb.push_back(e);
        end
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            start = hold;
            if (hold) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            if (j == inj) begin
                start    = 1'b1;
                dividend = W'($urandom_range(1, 255));
                divisor  = W'($urandom_range(1, 255));
            end
            if (j == rst_at) begin
                start  = 1'b0;
                rst    = 1'b1;
                last_q = 0;
                last_r = 0;
                last_z = 0;
                @(negedge clk);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_quotient", {24'd0, quotient}, 32'd0);
`ifdef SEQ_DIV_REMAINDER_EN
                chk("abort_remainder", {24'd0, remainder}, 32'd0);
`endif
                chk("abort_dz", {31'd0, dz}, 32'd0);
                rst = 1'b0;
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a;
        int b;
        int inj;
        int gap;
        bit hold;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_quotient", {24'd0, quotient}, 32'd0);
`ifdef SEQ_DIV_REMAINDER_EN
        chk("reset_remainder", {24'd0, remainder}, 32'd0);
`endif
        chk("reset_dz", {31'd0, dz}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // First start on the first edge after reset release
        div(100, 7, 1'b0, 0, 0);
        div(200, 0, 1'b0, 0, 0);      // back-to-back from DONE, dz case
        idle(2);
        div(5, 9, 1'b0, 0, 0);
        div(255, 1, 1'b0, 0, 0);
        idle(1);

        // Stray start at E3 must not disturb the running division
        div(100, 7, 1'b0, 3, 0);
        idle(1);

        // Reset at E4 aborts; next start right after release completes
        div(123, 4, 1'b0, 0, 4);
        div(77, 5, 1'b0, 0, 0);
        idle(2);

        // start held high continuously: one done every W+1 cycles
        div(250, 3, 1'b1, 0, 0);
        div(17, 17, 1'b1, 0, 0);
        div(0, 9, 1'b1, 0, 0);
        div(201, 13, 1'b1, 0, 0);
        idle(2);

        // Random sweep
        for (int it = 0; it < 200; it++) begin
            a    = int'($urandom_range(0, 255));
            b    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            hold = ($urandom_range(0, 2) == 0);
            inj  = (b != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            div(a, b, hold, inj, 0);
            gap = int'($urandom_range(0, 2));
            if (gap > 0 || it == 199) idle(gap + 1);
        end

        idle(4);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
